// File: rtl/sr_ff_bank_if.sv
// Bus bundle for sr_ff_bank: per-channel controls in, state and status out.
interface sr_ff_bank_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             clr_stat;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] chg;
    logic             conflict;
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output en, mode, s, r, clr_stat,
        input  q, qn, chg, conflict, chg_cnt
    );

    modport slave (
        input  en, mode, s, r, clr_stat,
        output q, qn, chg, conflict, chg_cnt
    );
endinterface

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent flip-flops, each acting as SR/JK/D/T per the shared mode
// select, with a per-channel change pulse, sticky SR-conflict flag and saturating
// change counter.
module sr_ff_bank #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      CONFLICT = 0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int unsigned      CNT_W    = 16
) (
    input logic          clk,
    input logic          rst,
    sr_ff_bank_if.slave  bus
);
    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] chg_q;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             any_chg;
    logic             conflict_evt;

    // Per-channel next state; holds when disabled.
    always_comb begin
        q_d = q_q;
        if (bus.en) begin
            for (int i = 0; i < WIDTH; i++) begin
                unique case (bus.mode)
                    MODE_SR: begin
                        case ({bus.s[i], bus.r[i]})
                            2'b10: q_d[i] = 1'b1;
                            2'b01: q_d[i] = 1'b0;
                            2'b11: begin
                                case (CONFLICT)
                                    1:       q_d[i] = 1'b1;
                                    2:       q_d[i] = 1'b0;
                                    3:       q_d[i] = ~q_q[i];
                                    default: q_d[i] = q_q[i];
                                endcase
                            end
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    MODE_JK: begin
                        case ({bus.s[i], bus.r[i]})
                            2'b10:   q_d[i] = 1'b1;
                            2'b01:   q_d[i] = 1'b0;
                            2'b11:   q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    MODE_D: q_d[i] = bus.s[i];
                    MODE_T: begin
                        // Forced clear outranks toggle.
                        if (bus.r[i]) begin
                            q_d[i] = 1'b0;
                        end else if (bus.s[i]) begin
                            q_d[i] = ~q_q[i];
                        end else begin
                            q_d[i] = q_q[i];
                        end
                    end
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
    end

    // Status next state; an event in the clearing cycle survives the clear.
    always_comb begin
        conflict_evt = bus.en && (bus.mode == MODE_SR) && (|(bus.s & bus.r));
        any_chg      = |(q_d ^ q_q);
        conflict_d   = bus.clr_stat ? conflict_evt : (conflict_q | conflict_evt);
        cnt_d        = cnt_q;
        if (bus.clr_stat) begin
            cnt_d = any_chg ? CNT_ONE : '0;
        end else if (any_chg && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers; chg reports the change from the previous edge one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= RST_VAL;
            diff_q     <= '0;
            chg_q      <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            diff_q     <= q_d ^ q_q;
            chg_q      <= diff_q;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.qn       = ~q_q;
    assign bus.chg      = chg_q;
    assign bus.conflict = conflict_q;
    assign bus.chg_cnt  = cnt_q;
endmodule

// File: doc/sr_ff_bank.md
SR_FF_BANK -- requirements
Module: sr_ff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent flip-flop channels (1..64).
REQ-002 SHALL have parameter CONFLICT, default 0, SR-mode S=R=1 policy: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
REQ-003 SHALL have parameter RST_VAL, default {WIDTH{0}}, the reset value of q.
REQ-004 SHALL have parameter CNT_W, default 16, the width of the change counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-007 SHALL have port en, input, 1, the update enable; when low, q holds.
REQ-008 SHALL have port mode, input, 2, the function select: 00 SR, 01 JK, 10 D, 11 T.
REQ-009 SHALL have port s, input, WIDTH, the per-channel S/J/D/T input.
REQ-010 SHALL have port r, input, WIDTH, the per-channel R/K input, or forced clear in T mode; ignored in D mode.
REQ-011 SHALL have port clr_stat, input, 1, the synchronous clear of conflict and chg_cnt.
REQ-012 SHALL have port q, output, WIDTH, the registered state.
REQ-013 SHALL have port qn, output, WIDTH, equal to ~q, combinational from q only.
REQ-014 SHALL have port chg, output, WIDTH, a registered one-cycle pulse per channel whose q changed on the previous edge.
REQ-015 SHALL have port conflict, output, 1, a sticky flag: an SR-mode S=R=1 occurred while en=1.
REQ-016 SHALL have port chg_cnt, output, CNT_W, a saturating count of edges on which any q bit changed.

Function
REQ-017 SHALL compute next-q per channel when en=1 using mode sampled at the same edge; latency one clock from input to q.
REQ-018 SR mode SHALL apply: 00 hold, 10 set, 01 clear, 11 per CONFLICT; never drive X.
REQ-019 JK mode SHALL apply: 00 hold, 10 set, 01 clear, 11 toggle, independent of CONFLICT.
REQ-020 D mode SHALL load q <= s.
REQ-021 T mode SHALL apply: r=1 forces 0 (priority over s); otherwise s=1 toggles and s=0 holds.
REQ-022 SHALL hold q, keep chg at 0 and leave conflict and chg_cnt unchanged when en=0, regardless of mode, s or r.
REQ-023 SHALL set chg[i] on the edge after q[i] changes, for exactly one cycle per change; chg SHALL be 0 when q is rewritten with an unchanged value.
REQ-024 SHALL increment chg_cnt by 1 on each edge where next-q differs from q in at least one bit, saturating at 2^CNT_W-1 with no wrap.
REQ-025 SHALL set conflict on any edge with en=1, mode=00 and (s & r) nonzero; it stays set until clr_stat or rst.
REQ-026 SHALL let an event in the same cycle as clr_stat win: conflict is 1 if a conflict occurs that cycle, else 0; chg_cnt is 1 if a change occurs that cycle, else 0.
REQ-027 SHALL NOT affect q or chg by clr_stat.
REQ-028 SHALL apply a mode change on the same edge it is sampled, with no pipeline or flush cycle.

Reset
REQ-029 SHALL, on rst=1 at a rising edge, set q=RST_VAL, chg=0, conflict=0 and chg_cnt=0, overriding en, clr_stat and all inputs.
REQ-030 SHALL NOT count a reset-induced q change in chg_cnt or flag it in chg.
REQ-031 SHALL resume normal operation on the first edge with rst=0, after reset asserted mid-operation.

Verification
REQ-032 Reset then SR mode, WIDTH=8, s=0x0F, r=0xF0, en=1 -> q=0x0F next cycle; chg=0x0F one cycle later; chg_cnt=1.
REQ-033 SR mode, CONFLICT=1/2/3, q=0x00, s=r=0x01 -> q=0x01, 0x00 and 0x01 respectively; conflict=1 and stays 1 on subsequent clean cycles.
REQ-034 JK mode s=r=0xFF for 3 edges from q=0x00 -> q toggles 0xFF, 0x00, 0xFF; chg=0xFF each cycle; chg_cnt += 3; conflict unchanged.
REQ-035 T mode s=0xFF, r=0x80, q=0x00 -> q=0x7F; en=0 with any inputs for 5 cycles -> q=0x7F, chg=0, chg_cnt unchanged.
REQ-036 CNT_W=2, force 5 changing edges -> chg_cnt=3 (saturated); clr_stat together with a changing edge -> chg_cnt=1; clr_stat alone -> chg_cnt=0.
REQ-037 rst asserted mid-sequence with en=1 and s=0xFF -> q=RST_VAL, chg=0, chg_cnt=0, conflict=0 at the next edge.
